uart_rx: RTL

Asynchronous serial receiver that is the downstream partner of the `UART` transmitter. It consumes the transmitter's `tx` line, or an external RX pin, using the same 8N1 framing: one start bit (0), 8 data bits LSB first, one stop bit (1). It recovers each byte by mid-bit majority sampling and presents it on a one-cycle valid strobe, with a framing-error strobe for bad stop bits. It sits between the pad/loopback line and the byte consumer (FIFO or command parser).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit period and receiver state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // Two-of-three vote used to reject single-sample noise on the line.
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input plus a 3-sample majority vote
// over the synchronized history. Usable for any slow asynchronous control line.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic sig_sync,
    output logic sig_vote
);

    logic [1:0] sync_r;
    logic [2:0] hist_r;

    // Metastability filter and sample history, both idling at the line's rest level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b11;
            hist_r <= 3'b111;
        end else begin
            sync_r <= {sync_r[0], sig};
            hist_r <= {hist_r[1:0], sync_r[1]};
        end
    end

    assign sig_sync = sync_r[1];
    assign sig_vote = majority3(hist_r);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification, mid-bit majority sampling,
// LSB-first assembly and stop-bit check with valid / framing-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned      HALF      = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] VOTE_AT   = CNT_W'(HALF + 1);
    localparam logic [2:0]       BIDX_LAST = 3'(UART_DATA_BITS - 1);

    logic                      rx_sync_s;
    logic                      vote_s;
    logic                      vote_now_s;

    uart_state_e               state_r,  state_next_s;
    logic [CNT_W-1:0]          cnt_r,    cnt_next_s;
    logic [2:0]                bidx_r,   bidx_next_s;
    logic [UART_DATA_BITS-1:0] shift_r,  shift_next_s;
    logic [7:0]                rx_data_r, rx_data_next_s;
    logic                      rx_valid_r, rx_valid_next_s;
    logic                      frame_err_r, frame_err_next_s;
    logic                      rx_busy_r;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .sig      (rx),
        .sig_sync (rx_sync_s),
        .sig_vote (vote_s)
    );

    assign vote_now_s = (cnt_r == VOTE_AT);

    // Next-state, datapath updates and strobe generation.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = (cnt_r == CNT_LAST) ? CNT_W'(0) : cnt_r + CNT_W'(1);
        bidx_next_s      = bidx_r;
        shift_next_s     = shift_r;
        rx_data_next_s   = rx_data_r;
        rx_valid_next_s  = 1'b0;
        frame_err_next_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_next_s = CNT_W'(0);
                if (!rx_sync_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                // cnt keeps running so later votes land one bit period apart
                if (vote_now_s && vote_s) begin
                    state_next_s = ST_IDLE;
                end else if (vote_now_s) begin
                    state_next_s = ST_DATA;
                    bidx_next_s  = 3'd0;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (vote_now_s) begin
                    shift_next_s = {vote_s, shift_r[UART_DATA_BITS-1:1]};
                    if (bidx_r == BIDX_LAST) begin
                        state_next_s = ST_STOP;
                    end else begin
                        bidx_next_s = bidx_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                // leave at the stop-bit centre so a zero-gap next start edge is caught
                if (vote_now_s && vote_s) begin
                    rx_data_next_s  = shift_r;
                    rx_valid_next_s = 1'b1;
                    state_next_s    = ST_IDLE;
                end else if (vote_now_s) begin
                    frame_err_next_s = 1'b1;
                    state_next_s     = ST_BREAK;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                cnt_next_s = CNT_W'(0);
                if (rx_sync_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_W'(0);
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_W'(0);
            bidx_r      <= 3'd0;
            shift_r     <= {UART_DATA_BITS{1'b0}};
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            rx_busy_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            bidx_r      <= bidx_next_s;
            shift_r     <= shift_next_s;
            rx_data_r   <= rx_data_next_s;
            rx_valid_r  <= rx_valid_next_s;
            frame_err_r <= frame_err_next_s;
            rx_busy_r   <= (state_next_s != ST_IDLE);
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign rx_busy   = rx_busy_r;

endmodule
